conv_stream_engine: RTL
=======================

# conv_stream_engine

Streaming 2-D convolution engine generalising the fixed 3x3, single-RAM-fed convolution datapath to a parametrised KxK kernel over a WxH frame, with valid/ready handshakes on both sides. It accepts pixels raster-order, maintains a line-buffer window internally, and emits one saturated result per fully-valid window position. It sits between a pixel source (RAM reader or upstream stream) and the result sink in the accelerator.

## Interface

**Parameters**
- `N`, default 8: pixel / coefficient / result width.
- `K`, default 3: kernel size, KxK. Legal range is odd, 3..7.
- `W`, default 16: pixels per row. Must satisfy W ≥ K.
- `H`, default 16: rows per frame. Must satisfy H ≥ K.
- `SHIFT`, default 0: arithmetic right shift applied to the accumulator before clamping.

**Ports** (name, direction, width, meaning)
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `kernel_load` in 1: latch `kernel` into the coefficient register. Honoured only while `busy` = 0.
- `kernel` in N*K*K: coefficients, signed two's complement. Coefficient (r,c) sits at bits [(r*K+c)*N +: N]. (0,0) is the oldest pixel, top-left.
- `s_valid` in 1, `s_data` in N (unsigned pixel), `s_ready` out 1: input stream.
- `m_valid` out 1, `m_data` out N (unsigned result), `m_ready` in 1: output stream.
- `m_last` out 1: qualifies the final result of the frame.
- `busy` out 1: frame in progress.

## Operation

- **Window storage:** shift chain of (K-1)*W+K pixels. Tap (r,c) = chain position r*W+c, counted from oldest. The chain shifts only on an input handshake (`s_valid & s_ready`).
- **Counters:** `col` (0..W-1) and `row` (0..H-1) give the position of the accepted pixel. Both advance on handshake; `col` wraps to 0 and increments `row`.
- **Window-valid rule:** a window is valid when the accepted pixel has `col` ≥ K-1 and `row` ≥ K-1. This yields (W-K+1)*(H-K+1) outputs per frame; partial windows that straddle row ends are never emitted.
- **Pending flag:** `pend` is set on the accepting edge of a valid window.
- **Arithmetic:**
  - acc = Σ kernel(r,c) * tap(r,c), with pixels zero-extended.
  - ACCW = 2N+1+clog2(K*K), signed.
  - res = acc >>> SHIFT, then clamped to [0, 2^N-1].
- **Output register:** loads res and m_valid ← pend whenever `!m_valid | m_ready`; otherwise it holds.
- **Input ready:** `s_ready` = (state != DRAIN) & (!pend | !m_valid | m_ready).
- **FSM:**
  - IDLE: busy = 0, `s_ready` per rule above. First input handshake → RUN.
  - RUN: on handshake of pixel W*H-1 → DRAIN.
  - DRAIN: `s_ready` = 0. Output handshake with `m_last` → IDLE, with counters, chain and pend cleared.
- **kernel_load:**
  - In IDLE, captured at the clock edge.
  - Ignored when `busy` = 1.
  - When kernel_load coincides with the first pixel handshake, the new kernel is captured and applies to the frame.
- **Reset** (any time, including mid-frame):
  - Outputs: `m_valid` = 0, `m_data` = 0, `m_last` = 0, `busy` = 0.
  - Internal: state IDLE, counters 0, chain 0, pend 0, coefficients 0.
  - `s_ready` = 1 after reset is released.

## Timing

- **Latency:** a valid window accepted at edge t drives `m_valid` high after edge t+1, assuming `m_ready` was held high.
- **Throughput:** 1 pixel/cycle under continuous `m_ready`.
- **Backpressure:** `m_valid` & !`m_ready` holds `m_data` and `m_last` stable. `s_ready` drops the cycle after `pend` and a held output coexist. No data is lost or duplicated.
- **m_last:** asserted with the result of window (row H-1, col W-1).
- **busy:** rises the cycle after the first pixel handshake and falls after the `m_last` handshake edge.
- **Back-to-back frames:** the next frame's first pixel may be accepted the cycle after `busy` falls.

## Structure

- **Package `conv_pkg`:**
  - State enum {IDLE, RUN, DRAIN}.
  - ACCW computation function.
  - Clamp/shift function.
  - Coefficient index helper.
- **Sub-module `conv_mac_tree`:** combinational K*K signed multiply plus adder tree. It takes the flat window and flat kernel and returns acc (ACCW bits).
- **Top level:** chain, counters, FSM, pend/output register.

## Test plan

1. **Identity kernel, ramp.** K=3, W=H=4, identity kernel (center 1, others 0), pixels 0..15 → outputs 5, 6, 9, 10. `m_last` is asserted only on 10.
2. **Saturation.** All-ones kernel, all pixels 255 → 255 (clamped from 2295). Kernel all -1 → 0. All-ones kernel with SHIFT=3 and pixels 8 → 9.
3. **Backpressure.** Same as scenario 1 with `m_ready` low for 5 cycles mid-frame → `m_data` held, `s_ready` drops, output sequence unchanged, exactly 4 results.
4. **kernel_load while busy.** Assert kernel_load with a zero kernel while `busy` = 1 → ignored, results match the original kernel. Assert it again while in IDLE → the next frame outputs 0.
5. **Reset mid-frame.** Assert rst after 7 pixels → all outputs 0 immediately. Then a full frame with the kernel reloaded → the scenario 1 results.
6. **Back-to-back frames.** Two frames streamed with no gap and random `s_valid` gaps → 8 results total, with `m_last` on the 4th and 8th.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming KxK convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Signed accumulator width: full product plus growth for K*K terms.
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned k);
    return 2 * n + 1 + $clog2(k * k);
  endfunction

  // Flat index of coefficient / window tap (r,c).
  function automatic int unsigned coef_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned k);
    return r * k + c;
  endfunction

  // Arithmetic shift then clamp into the unsigned n-bit range.
  function automatic logic [63:0] shift_clamp(input logic signed [63:0] acc,
                                              input int unsigned sh, input int unsigned n);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    s  = acc >>> sh;
    hi = (64'sd1 <<< n) - 64'sd1;
    if (s < 64'sd0) return '0;
    else if (s > hi) return hi;
    else return s;
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// Combinational KxK signed multiply-accumulate over a flat window and kernel.
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned K    = 3,
  parameter int unsigned ACCW = 21
) (
  input  logic [N*K*K-1:0]       window_i,
  input  logic [N*K*K-1:0]       kernel_i,
  output logic signed [ACCW-1:0] acc_o
);

  logic signed [ACCW-1:0] kx;
  logic signed [ACCW-1:0] px;

  // Sum of products; coefficients sign-extended, pixels zero-extended.
  always_comb begin
    acc_o = '0;
    kx    = '0;
    px    = '0;
    for (int unsigned i = 0; i < K * K; i++) begin
      kx    = ACCW'(signed'(kernel_i[i*N +: N]));
      px    = ACCW'({1'b0, window_i[i*N +: N]});
      acc_o = acc_o + kx * px;
    end
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution: line-buffer shift chain, raster counters,
// frame FSM and a single-entry pending/output register pair.
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned K     = 3,
  parameter int unsigned W     = 16,
  parameter int unsigned H     = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kernel_load,
  input  logic [N*K*K-1:0] kernel,
  input  logic             s_valid,
  input  logic [N-1:0]     s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [N-1:0]     m_data,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy
);

  localparam int unsigned ACCW  = acc_width(N, K);
  localparam int unsigned CHAIN = (K - 1) * W + K;
  localparam int unsigned CW    = $clog2(W);
  localparam int unsigned RW    = $clog2(H);

  state_e                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CHAIN*N-1:0]     chain_q, chain_d;
  logic                   pend_q, pend_d;
  logic                   pend_last_q, pend_last_d;
  logic [N*K*K-1:0]       coef_q, coef_d;
  logic                   m_valid_q, m_valid_d;
  logic [N-1:0]           m_data_q, m_data_d;
  logic                   m_last_q, m_last_d;

  logic                   hs, out_ld, win_ok, last_px, clear;
  logic [N*K*K-1:0]       window;
  logic signed [ACCW-1:0] acc;
  logic [N-1:0]           res;

  assign hs      = s_valid & s_ready;
  assign out_ld  = !m_valid_q | m_ready;
  assign win_ok  = (col_q >= CW'(K - 1)) && (row_q >= RW'(K - 1));
  assign last_px = (col_q == CW'(W - 1)) && (row_q == RW'(H - 1));
  assign s_ready = (state_q != StDrain) & (!pend_q | out_ld);
  assign busy    = (state_q != StIdle);
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

  // Gather the KxK taps out of the chain; tap (r,c) sits at r*W+c from the oldest end.
  always_comb begin
    window = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        window[coef_idx(r, c, K)*N +: N] = chain_q[(r*W+c)*N +: N];
      end
    end
  end

  conv_mac_tree #(
    .N    (N),
    .K    (K),
    .ACCW (ACCW)
  ) u_mac (
    .window_i (window),
    .kernel_i (coef_q),
    .acc_o    (acc)
  );

  assign res = N'(shift_clamp(64'(acc), SHIFT, N));

  // Frame FSM next state; the m_last handshake closes the frame.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle:  if (hs) state_d = StRun;
      StRun:   if (hs && last_px) state_d = StDrain;
      StDrain: begin
        if (m_valid_q && m_ready && m_last_q) begin
          state_d = StIdle;
          clear   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Chain, counters, pending flag, coefficients and output register next state.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    chain_d     = chain_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    if (out_ld) begin
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
    end
    if (hs) begin
      chain_d = {s_data, chain_q[CHAIN*N-1:N]};
      if (col_q == CW'(W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      pend_d      = win_ok;
      pend_last_d = win_ok & last_px;
    end
    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      chain_d     = '0;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
    end
    coef_d    = (state_q == StIdle && kernel_load) ? kernel : coef_q;
    m_valid_d = out_ld ? pend_q : m_valid_q;
    m_data_d  = out_ld ? res : m_data_q;
    m_last_d  = out_ld ? (pend_q & pend_last_q) : m_last_q;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      chain_q     <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      coef_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      chain_q     <= chain_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      coef_q      <= coef_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
    end
  end

endmodule
